bcast_fanout_buf: RTL and testbench
===================================

BCAST_FANOUT_BUF -- requirements
Module: bcast_fanout_buf

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data width in bits.
REQ-002 SHALL have parameter N_OUT, default 4: number of consumer ports, legal range 2..16.
REQ-003 SHALL have parameter DEPTH, default 4: FIFO entries, power of two, legal range 2..16.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port in_valid, input, 1 bit: producer offers in_data.
REQ-007 SHALL have port in_data, input, WIDTH bits: producer payload.
REQ-008 SHALL have port in_ready, output, 1 bit: block accepts in_data this cycle.
REQ-009 SHALL have port out_data, output, WIDTH bits: head payload, shared by all consumers.
REQ-010 SHALL have port out_valid, output, N_OUT bits: per-consumer valid.
REQ-011 SHALL have port out_ready, input, N_OUT bits: per-consumer ready.
REQ-012 SHALL have port level, output, $clog2(DEPTH)+1 bits: current FIFO occupancy.
REQ-013 SHALL have port bcast_cnt, output, 16 bits: count of fully delivered items.

Function
REQ-014 SHALL push in_data on a cycle where in_valid && in_ready.
REQ-015 SHALL drive in_ready = (level < DEPTH), taken from registered state only; pop activity in the same cycle does not affect it, so there is no combinational path from out_ready to in_ready.
REQ-016 SHALL use a circular buffer with wr_ptr and rd_ptr wrapping from DEPTH-1 to 0.
REQ-017 SHALL have a latency of one cycle: an item pushed at edge t is visible on out_data/out_valid after edge t, provided the FIFO was empty.
REQ-018 SHALL hold a per-consumer taken mask, N_OUT bits, which records consumers that have already accepted the head item.
REQ-019 SHALL drive out_valid[i] = (level != 0) && !taken[i].
REQ-020 SHALL count consumer i as firing on a cycle where out_valid[i] && out_ready[i].
REQ-021 SHALL pop on a cycle where (taken | fire) == all ones: rd_ptr advances, taken clears to 0, and bcast_cnt increments.
REQ-022 When no pop occurs, SHALL set taken <= taken | fire.
REQ-023 SHALL allow consumers to accept the head in any order and across any number of cycles; a consumer that has taken the head sees out_valid[i]=0 until the next item arrives.
REQ-024 SHALL allow push and pop in the same cycle: level stays unchanged, and both pointers advance.
REQ-025 At empty (level=0), SHALL hold out_valid all zeros and keep taken at zero; out_data is don't-care.
REQ-026 At full (level=DEPTH), SHALL hold in_ready=0, and in_data is ignored even if in_valid=1.
REQ-027 SHALL hold out_data stable while the head is not popped.
REQ-028 SHALL let bcast_cnt wrap from 0xFFFF to 0x0000 with no flag.
REQ-029 SHALL treat out_ready bits asserted while the corresponding out_valid is low as having no effect.

Reset
REQ-030 While rst_n=0, SHALL immediately force: wr_ptr=0, rd_ptr=0, level=0, taken=0, bcast_cnt=0, out_valid=0, in_ready=0.
REQ-031 On the first clk edge after rst_n deasserts, SHALL set in_ready=1 (level=0 < DEPTH).
REQ-032 On reset assertion mid-operation, SHALL discard all stored items and partial taken state without completing delivery.
REQ-033 SHALL leave FIFO storage contents unreset; they are unobservable while level=0.

Verification
REQ-034 Single item: push 0xA5 with out_ready=4'b1111 held -> next cycle out_valid=4'b1111 and out_data=0xA5; one cycle later level=0, out_valid=0, and bcast_cnt=1.
REQ-035 Staggered accept: push 0x3C, then out_ready=4'b0001, then 4'b0100, then 4'b1010 -> out_valid goes 1111, 1110, 1010, 0000, and the pop happens on the third accept cycle only.
REQ-036 Full/back-pressure: out_ready=0 with 5 pushes attempted (DEPTH=4) -> level=4, in_ready=0 on the 5th, and 5th item absent; drain then yields items 1-4 in order.
REQ-037 Simultaneous push/pop at level=2 with all out_ready=1 -> level stays 2, and out_data advances to the next item.
REQ-038 Reset mid-delivery: level=3 and taken=4'b0011, rst_n pulsed low for half a cycle -> out_valid=0, level=0, and bcast_cnt=0 immediately, without waiting for a clk edge.
REQ-039 Counter wrap: force 0xFFFF deliveries (or preload via backdoor) -> next delivery gives bcast_cnt=0x0000.

Source files
------------

// File: rtl/bcast_fanout_buf.sv
// Broadcast fan-out buffer: a small FIFO whose head item is offered to N_OUT
// consumers at once and retired only after every consumer has accepted it.
module bcast_fanout_buf #(
  parameter int WIDTH = 8,
  parameter int N_OUT = 4,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   in_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [N_OUT-1:0]       out_valid,
  input  logic [N_OUT-1:0]       out_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic [15:0]            bcast_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR   = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [N_OUT-1:0] taken_q, taken_d;
  logic [15:0]      bcast_cnt_q, bcast_cnt_d;
  logic             in_ready_q, in_ready_d;

  logic             not_empty;
  logic [N_OUT-1:0] fire;
  logic             push;
  logic             pop;

  assign not_empty = (level_q != '0);

  // A consumer that already holds the head is masked off until the next item.
  genvar gi;
  generate
    for (gi = 0; gi < N_OUT; gi++) begin : g_cons
      assign out_valid[gi] = not_empty & ~taken_q[gi];
      assign fire[gi]      = out_valid[gi] & out_ready[gi];
    end
  endgenerate

  always_comb begin
    push        = in_valid & in_ready_q;
    pop         = not_empty & ((taken_q | fire) == {N_OUT{1'b1}});
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    taken_d     = taken_q | fire;
    bcast_cnt_d = bcast_cnt_q;

    if (push) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    end

    if (pop) begin
      rd_ptr_d    = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      taken_d     = '0;
      bcast_cnt_d = bcast_cnt_q + 16'd1;
    end

    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    // Registered so out_ready never reaches in_ready combinationally.
    in_ready_d = (level_d < FULL_LEVEL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      taken_q     <= '0;
      bcast_cnt_q <= '0;
      in_ready_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      taken_q     <= taken_d;
      bcast_cnt_q <= bcast_cnt_d;
      in_ready_q  <= in_ready_d;
    end
  end

  // Storage is not reset; stale entries are never visible while level is 0.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  assign out_data  = mem_q[rd_ptr_q];
  assign in_ready  = in_ready_q;
  assign level     = level_q;
  assign bcast_cnt = bcast_cnt_q;

endmodule

// File: tb/tb_bcast_fanout_buf.sv
// Self-checking bench for bcast_fanout_buf: scoreboard queue of pushed items
// plus a small behavioural model of the taken mask and delivery counter.
module tb_bcast_fanout_buf;

  localparam int WIDTH = 8;
  localparam int N_OUT = 4;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic [N_OUT-1:0] out_valid;
  logic [N_OUT-1:0] out_ready = '0;
  logic [LW-1:0]    level;
  logic [15:0]      bcast_cnt;

  always #5 clk = ~clk;

  bcast_fanout_buf #(.WIDTH(WIDTH), .N_OUT(N_OUT), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .bcast_cnt (bcast_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit quiet    = 1'b0;

  logic [WIDTH-1:0] sb_q[$];
  logic [N_OUT-1:0] m_taken = '0;
  logic [15:0]      m_cnt   = '0;
  logic             m_rdy   = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: called just after a falling edge, returns at the next one.
  task automatic cycle(input logic iv, input logic [WIDTH-1:0] id, input logic [N_OUT-1:0] ordy);
    logic [N_OUT-1:0] exp_vld;
    logic [N_OUT-1:0] fire;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] head;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    #1;
    exp_vld = (sb_q.size() != 0) ? ~m_taken : '0;
    check_val("level", 32'(level), 32'(sb_q.size()));
    check_val("out_valid", 32'(out_valid), 32'(exp_vld));
    check_val("in_ready", 32'(in_ready), 32'(m_rdy));
    check_val("bcast_cnt", 32'(bcast_cnt), 32'(m_cnt));
    if (sb_q.size() != 0) check_val("out_data", 32'(out_data), 32'(sb_q[0]));
    fire = exp_vld & ordy;
    push = iv && m_rdy;
    pop  = (sb_q.size() != 0) && ((m_taken | fire) == {N_OUT{1'b1}});
    @(posedge clk);
    if (pop) begin
      head    = sb_q.pop_front();
      m_taken = '0;
      m_cnt   = m_cnt + 16'd1;
    end else begin
      m_taken = m_taken | fire;
    end
    if (push) sb_q.push_back(id);
    m_rdy = (sb_q.size() < DEPTH);
    @(negedge clk);
    if (!quiet)
      $display("t=%0t iv=%0b din=%02h ordy=%b push=%0b pop=%0b | lvl=%0d vld=%b dout=%02h cnt=%0d",
               $time, iv, id, ordy, push, pop, level, out_valid, out_data, bcast_cnt);
  endtask

  initial begin
    // Reset state, applied asynchronously
    #1 rst_n = 1'b0;
    #1;
    check_val("rst_level", 32'(level), 32'd0);
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_in_ready", 32'(in_ready), 32'd0);
    check_val("rst_bcast_cnt", 32'(bcast_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // First cycle after release still reports in_ready=0 (checked in cycle)
    cycle(1'b0, 8'h00, 4'h0);
    check_val("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Single item with all consumers ready
    cycle(1'b1, 8'hA5, 4'hF);
    check_val("single_vld", 32'(out_valid), 32'hF);
    check_val("single_data", 32'(out_data), 32'hA5);
    cycle(1'b0, 8'h00, 4'hF);
    check_val("single_level", 32'(level), 32'd0);
    check_val("single_vld_after", 32'(out_valid), 32'd0);
    check_val("single_cnt", 32'(bcast_cnt), 32'd1);

    // Staggered accept
    cycle(1'b1, 8'h3C, 4'h0);
    check_val("stag_vld0", 32'(out_valid), 32'hF);
    cycle(1'b0, 8'h00, 4'b0001);
    check_val("stag_vld1", 32'(out_valid), 32'hE);
    check_val("stag_lvl1", 32'(level), 32'd1);
    cycle(1'b0, 8'h00, 4'b0100);
    check_val("stag_vld2", 32'(out_valid), 32'hA);
    check_val("stag_lvl2", 32'(level), 32'd1);
    check_val("stag_data", 32'(out_data), 32'h3C);
    cycle(1'b0, 8'h00, 4'b1010);
    check_val("stag_vld3", 32'(out_valid), 32'h0);
    check_val("stag_lvl3", 32'(level), 32'd0);
    check_val("stag_cnt", 32'(bcast_cnt), 32'd2);

    // Full / back-pressure: five pushes, the fifth must be dropped
    for (int k = 0; k < 5; k++) cycle(1'b1, 8'((k + 1) * 8'h11), 4'h0);
    check_val("full_level", 32'(level), 32'd4);
    check_val("full_in_ready", 32'(in_ready), 32'd0);
    for (int k = 0; k < 4; k++) begin
      check_val("drain_data", 32'(out_data), 32'((k + 1) * 8'h11));
      cycle(1'b0, 8'h00, 4'hF);
    end
    check_val("drain_level", 32'(level), 32'd0);
    check_val("drain_cnt", 32'(bcast_cnt), 32'd6);

    // Simultaneous push and pop at level 2
    cycle(1'b1, 8'h51, 4'h0);
    cycle(1'b1, 8'h52, 4'h0);
    check_val("sim_level_pre", 32'(level), 32'd2);
    cycle(1'b1, 8'h53, 4'hF);
    check_val("sim_level_post", 32'(level), 32'd2);
    check_val("sim_data", 32'(out_data), 32'h52);
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) cycle(1'b0, 8'h00, 4'hF);

    // Random traffic against the scoreboard
    for (int i = 0; i < 300; i++)
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 4'($urandom));
    for (int i = 0; i < 50 && sb_q.size() != 0; i++) cycle(1'b0, 8'h00, 4'hF);
    check_val("rand_empty", 32'(level), 32'd0);

    // Reset in the middle of a partial delivery
    for (int k = 0; k < 3; k++) cycle(1'b1, 8'(8'hC0 + k), 4'h0);
    cycle(1'b0, 8'h00, 4'b0011);
    check_val("mid_vld", 32'(out_valid), 32'hC);
    check_val("mid_level", 32'(level), 32'd3);
    rst_n = 1'b0;
    #1;
    check_val("arst_vld", 32'(out_valid), 32'd0);
    check_val("arst_level", 32'(level), 32'd0);
    check_val("arst_cnt", 32'(bcast_cnt), 32'd0);
    check_val("arst_in_ready", 32'(in_ready), 32'd0);
    #3 rst_n = 1'b1;
    sb_q.delete();
    m_taken = '0;
    m_cnt   = '0;
    @(posedge clk);
    m_rdy = 1'b1;
    @(negedge clk);
    check_val("arst_recover_rdy", 32'(in_ready), 32'd1);

    // Counter wrap: stream deliveries until the count reaches 0xFFFF
    quiet = 1'b1;
    for (int i = 0; i < 70000 && m_cnt != 16'hFFFF; i++) cycle(1'b1, 8'(i), 4'hF);
    quiet = 1'b0;
    check_val("wrap_pre", 32'(bcast_cnt), 32'hFFFF);
    for (int i = 0; i < 5 && sb_q.size() != 0; i++) cycle(1'b0, 8'h00, 4'hF);
    check_val("wrap_post", 32'(bcast_cnt), 32'h0000);
    check_val("wrap_level", 32'(level), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
